// File: rtl/id_entry.sv
// Four-digit BCD ID entry: digits are staged calculator-style and copied into the
// committed ID on commit. Define ID_BACKSPACE_EN to enable the backspace strobe.
module id_entry #(
   parameter logic [15:0] RESET_ID = 16'h1119
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  digit_in,
   input  logic        digit_valid,
   input  logic        backspace,
   input  logic        clear,
   input  logic        commit,
   input  logic [1:0]  rd_sel,
   output logic [3:0]  rd_data,
   output logic [15:0] id_word,
   output logic [2:0]  count,
   output logic        ready,
   output logic        committed,
   output logic        err,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ENTERING = 2'd1, READY = 2'd2} state_t;

   state_t      state, state_n;
   logic [15:0] stage, stage_n;
   logic [15:0] cid, cid_n;
   logic [2:0]  count_n;
   logic        committed_n, err_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         stage     <= 16'h0000;
         cid       <= RESET_ID;
         count     <= 3'd0;
         committed <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         stage     <= stage_n;
         cid       <= cid_n;
         count     <= count_n;
         committed <= committed_n;
         err       <= err_n;
      end
   end

   // Strobe priority: clear > commit > backspace > digit; losers are dropped silently.
   always_comb begin
      state_n     = state;
      stage_n     = stage;
      cid_n       = cid;
      count_n     = count;
      committed_n = 1'b0;
      err_n       = 1'b0;
      if (clear) begin
         stage_n = 16'h0000;
         count_n = 3'd0;
         state_n = EMPTY;
      end else if (commit) begin
         if (state == READY) begin
            cid_n       = stage;
            stage_n     = 16'h0000;
            count_n     = 3'd0;
            state_n     = EMPTY;
            committed_n = 1'b1;
         end else begin
            err_n = 1'b1;
         end
`ifdef ID_BACKSPACE_EN
      end else if (backspace) begin
         if (state == EMPTY) begin
            err_n = 1'b1;
         end else begin
            stage_n = {4'h0, stage[15:4]};
            count_n = count - 3'd1;
            state_n = (count == 3'd1) ? EMPTY : ENTERING;
         end
`endif
      end else if (digit_valid) begin
         if (digit_in > 4'd9 || state == READY) begin
            err_n = 1'b1;
         end else begin
            stage_n = {stage[11:0], digit_in};
            count_n = count + 3'd1;
            state_n = (count == 3'd3) ? READY : ENTERING;
         end
      end
   end

`ifndef ID_BACKSPACE_EN
   logic unused_backspace;
   assign unused_backspace = backspace;
`endif

   assign rd_data   = cid[{rd_sel, 2'b00} +: 4];
   assign id_word   = cid;
   assign ready     = (state == READY);
   assign state_dbg = state;

endmodule

// File: tb/tb_id_entry.sv
// Directed self-checking bench for id_entry; expectations are hand-computed BCD values.
module tb_id_entry;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  digit_in;
   logic        digit_valid;
   logic        backspace;
   logic        clear;
   logic        commit;
   logic [1:0]  rd_sel;
   logic [3:0]  rd_data;
   logic [15:0] id_word;
   logic [2:0]  count;
   logic        ready;
   logic        committed;
   logic        err;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_entry dut (
      .clk         (clk),
      .reset       (reset),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .backspace   (backspace),
      .clear       (clear),
      .commit      (commit),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .id_word     (id_word),
      .count       (count),
      .ready       (ready),
      .committed   (committed),
      .err         (err),
      .state_dbg   (state_dbg)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_digit(input logic [3:0] d);
      digit_in    = d;
      digit_valid = 1'b1;
      step();
      digit_valid = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic pulse_backspace();
      backspace = 1'b1;
      step();
      backspace = 1'b0;
   endtask

   initial begin
      reset = 1'b1; digit_in = 4'h0; digit_valid = 1'b0; backspace = 1'b0;
      clear = 1'b0; commit = 1'b0; rd_sel = 2'd0;
      step(); step();
      reset = 1'b0;
      step();

      // Reset state
      rd_sel = 2'd0; #1 check("rst_rd0", rd_data, 4'h9);
      rd_sel = 2'd1; #1 check("rst_rd1", rd_data, 4'h1);
      rd_sel = 2'd2; #1 check("rst_rd2", rd_data, 4'h1);
      rd_sel = 2'd3; #1 check("rst_rd3", rd_data, 4'h1);
      check("rst_id", id_word, 16'h1119);
      check("rst_count", count, 3'd0);
      check("rst_ready", ready, 1'b0);
      check("rst_committed", committed, 1'b0);
      check("rst_err", err, 1'b0);

      // Normal entry and commit of 2025
      send_digit(4'd2);
      send_digit(4'd0);
      send_digit(4'd2);
      check("e3_count", count, 3'd3);
      check("e3_ready", ready, 1'b0);
      send_digit(4'd5);
      check("e4_count", count, 3'd4);
      check("e4_ready", ready, 1'b1);
      check("e4_id_unchanged", id_word, 16'h1119);
      pulse_commit();
      check("c1_committed", committed, 1'b1);
      check("c1_err", err, 1'b0);
      check("c1_id", id_word, 16'h2025);
      check("c1_count", count, 3'd0);
      check("c1_ready", ready, 1'b0);
      rd_sel = 2'd3; #1 check("c1_rd3", rd_data, 4'h2);
      step();
      check("c1_pulse_width", committed, 1'b0);

      // Invalid digit, then premature commit
      send_digit(4'd7);
      check("bad_pre_count", count, 3'd1);
      send_digit(4'hA);
      check("bad_err", err, 1'b1);
      check("bad_count", count, 3'd1);
      step();
      check("bad_err_width", err, 1'b0);
      pulse_commit();
      check("early_commit_err", err, 1'b1);
      check("early_commit_no_pulse", committed, 1'b0);
      check("early_commit_id", id_word, 16'h2025);
      pulse_clear();
      check("clr_count", count, 3'd0);
      check("clr_err", err, 1'b0);

      // Overflow digit in READY, then clear+commit together
      send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
      send_digit(4'd5);
      check("ovf_err", err, 1'b1);
      check("ovf_count", count, 3'd4);
      clear = 1'b1; commit = 1'b1;
      step();
      clear = 1'b0; commit = 1'b0;
      check("cc_count", count, 3'd0);
      check("cc_committed", committed, 1'b0);
      check("cc_err", err, 1'b0);
      check("cc_id", id_word, 16'h2025);

      // Overflow digit must leave 1234 intact; commit beats a same-cycle digit
      send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
      send_digit(4'd5);
      check("ovf2_err", err, 1'b1);
      commit = 1'b1; digit_valid = 1'b1; digit_in = 4'd8;
      step();
      commit = 1'b0; digit_valid = 1'b0;
      check("retain_id", id_word, 16'h1234);
      check("retain_committed", committed, 1'b1);
      check("retain_err", err, 1'b0);
      check("retain_count", count, 3'd0);

      // Reset mid-entry
      send_digit(4'd3); send_digit(4'd4);
      check("mid_count", count, 3'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_count", count, 3'd0);
      check("mid_rst_id", id_word, 16'h1119);
      check("mid_rst_err", err, 1'b0);
      pulse_commit();
      check("mid_rst_commit_err", err, 1'b1);
      check("mid_rst_commit_id", id_word, 16'h1119);

      // Backspace behaviour
      step();
      pulse_backspace();
`ifdef ID_BACKSPACE_EN
      check("bs_empty_err", err, 1'b1);
`else
      check("bs_empty_err", err, 1'b0);
`endif
      send_digit(4'd5); send_digit(4'd6); send_digit(4'd7);
      pulse_backspace();
`ifdef ID_BACKSPACE_EN
      check("bs_count", count, 3'd2);
      check("bs_err", err, 1'b0);
      send_digit(4'd8); send_digit(4'd9);
      check("bs_ready", ready, 1'b1);
      pulse_commit();
      check("bs_id", id_word, 16'h5689);
`else
      check("bs_count", count, 3'd3);
      check("bs_err", err, 1'b0);
      send_digit(4'd8);
      check("bs_ready", ready, 1'b1);
      send_digit(4'd9);
      check("bs_5th_err", err, 1'b1);
      pulse_commit();
      check("bs_id", id_word, 16'h5678);
`endif
      check("bs_committed", committed, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_entry.md
ID_ENTRY -- requirements
Module: id_entry

Interface
REQ-001 Parameter RESET_ID, default 16'h1119: committed 4-digit BCD ID loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 digit_in  input  4  candidate digit value; sampled only when digit_valid=1.
REQ-005 digit_valid  input  1  one-cycle strobe presenting digit_in.
REQ-006 backspace  input  1  one-cycle strobe removing last entered digit (active only with ID_BACKSPACE_EN).
REQ-007 clear  input  1  one-cycle strobe discarding staged digits.
REQ-008 commit  input  1  one-cycle strobe copying staged digits to committed ID.
REQ-009 rd_sel  input  2  committed-digit select; 0 = rightmost, 3 = leftmost.
REQ-010 rd_data  output  4  committed digit selected by rd_sel.
REQ-011 id_word  output  16  full committed ID, digit 3 in [15:12].
REQ-012 count  output  3  number of staged digits, 0..4.
REQ-013 ready  output  1  high when 4 digits staged.
REQ-014 committed  output  1  one-cycle pulse after a successful commit.
REQ-015 err  output  1  one-cycle pulse on any rejected strobe.

Function
REQ-016 Staging register stage[15:0] and committed register cid[15:0] SHALL be separate; rd_data/id_word SHALL reflect cid only.
REQ-017 rd_data SHALL be combinational: cid[4*rd_sel+3 : 4*rd_sel], zero latency.
REQ-018 FSM states EMPTY (count=0), ENTERING (count 1..3), READY (count=4); ready=1 only in READY.
REQ-019 Accepted digit: stage <= {stage[11:0], digit_in}, count+1, registered next cycle (calculator-style left shift).
REQ-020 digit_valid with digit_in > 9 SHALL be rejected: stage/count unchanged, err=1 next cycle.
REQ-021 digit_valid in READY SHALL be rejected with err; stage unchanged (no wrap, no overwrite).
REQ-022 commit in READY: cid <= stage, stage <= 0, count <= 0, state -> EMPTY, committed=1 next cycle.
REQ-023 commit in EMPTY or ENTERING SHALL be rejected with err; cid unchanged.
REQ-024 clear: stage <= 0, count <= 0, state -> EMPTY from any state; cid unchanged; no err.
REQ-025 Priority for simultaneous strobes: clear > commit > backspace > digit_valid; lower-priority strobes same cycle SHALL be ignored silently (no err).
REQ-026 committed and err SHALL never assert in the same cycle; each is exactly one cycle wide.
REQ-027 count SHALL never exceed 4 nor underflow below 0.

Reset
REQ-028 reset SHALL set cid=RESET_ID, stage=0, count=0, state=EMPTY, ready=0, committed=0, err=0.
REQ-029 reset SHALL take priority over every strobe, including mid-entry; partial entry is discarded.
REQ-030 Outputs after reset: id_word=RESET_ID, rd_data per rd_sel from RESET_ID.

Configuration
REQ-031 Macro ID_BACKSPACE_EN defined: backspace in ENTERING/READY SHALL do stage <= {4'h0, stage[15:4]}, count-1, state per count; backspace in EMPTY SHALL pulse err.
REQ-032 ID_BACKSPACE_EN undefined: backspace port SHALL exist but be ignored entirely (no state change, no err).

Verification
REQ-033 Reset, rd_sel=0..3 -> rd_data=9,1,1,1; id_word=16'h1119; count=0.
REQ-034 Enter 2,0,2,5 then commit -> ready=1 after 4th digit; committed pulse; id_word=16'h2025; count=0.
REQ-035 Enter 7 then digit_in=4'hA -> err pulse, count stays 1; commit -> err, id_word unchanged.
REQ-036 Enter 1,2,3,4 then digit 5 -> err, stage 1234 retained; clear+commit same cycle -> count=0, no committed, no err.
REQ-037 Enter 3,4, assert reset -> count=0, id_word=16'h1119, following commit -> err.
REQ-038 With ID_BACKSPACE_EN: enter 5,6,7, backspace, enter 8,9, commit -> id_word=16'h5689; without macro same sequence -> err on 5th digit, commit yields 16'h5678.
